data_memory_bank: RTL and testbench
===================================

DATA_MEMORY_BANK -- requirements
Module: data_memory_bank

Interface
REQ-001 Parameter RAM_WIDTH, default 16, SHALL set the data word width in bits; it SHALL be a multiple of 8.
REQ-002 Parameter RAM_ADDR_BITS, default 11, SHALL set the address width; depth SHALL be 2**RAM_ADDR_BITS words.
REQ-003 Derived constant LANES = RAM_WIDTH/8 SHALL be the number of byte lanes.
REQ-004 Port clk, input, 1 bit: the single clock; reset is synchronous and active-high; all state SHALL update on the rising edge of clk.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req, input, 1 bit: access request, sampled on each rising edge.
REQ-007 Port write, input, 1 bit: 1 = write access, 0 = read access; qualified by req.
REQ-008 Port be, input, LANES bits: byte-lane write enable; bit i covers in_data[8i+7:8i].
REQ-009 Port addr_data, input, RAM_ADDR_BITS bits: word address.
REQ-010 Port in_data, input, RAM_WIDTH bits: write data.
REQ-011 Port out_data, output, RAM_WIDTH bits: registered read data.
REQ-012 Port rd_valid, output, 1 bit: one-cycle pulse marking new out_data.
REQ-013 Port busy, output, 1 bit: high while the array is being cleared.
REQ-014 Port err_busy, output, 1 bit: one-cycle pulse flagging a request rejected because busy was high.

Function
REQ-015 The block SHALL have two states: CLEAR and IDLE.
REQ-016 CLEAR: a RAM_ADDR_BITS-bit counter clr_cnt SHALL address the array; each cycle with rst low SHALL write all-zero to ram[clr_cnt] and increment clr_cnt.
REQ-017 CLEAR -> IDLE SHALL occur on the edge that writes address 2**RAM_ADDR_BITS-1; clearing SHALL take exactly 2**RAM_ADDR_BITS cycles after rst falls.
REQ-018 busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-019 IDLE write (req=1, write=1): on the edge, for every i with be[i]=1, lane i of ram[addr_data] SHALL take in_data lane i; lanes with be[i]=0 SHALL be unchanged; out_data and rd_valid SHALL be unaffected.
REQ-020 IDLE write with be all-zero SHALL leave the array unchanged and raise no error.
REQ-021 IDLE read (req=1, write=0): out_data SHALL take ram[addr_data] on the edge; rd_valid SHALL be 1 for exactly that following cycle. Read latency is 1 cycle.
REQ-022 out_data SHALL hold its value until the next completed read or reset.
REQ-023 Back-to-back reads on consecutive cycles SHALL each complete at one per cycle; rd_valid SHALL stay high across them.
REQ-024 Read of an address written in the previous cycle SHALL return the newly written data.
REQ-025 req=1 while busy=1 SHALL be ignored: no array change, no read; err_busy SHALL be 1 on the following cycle only.
REQ-026 req=0 SHALL cause no access; rd_valid and err_busy SHALL be 0 on the following cycle.
REQ-027 Addresses SHALL be fully decoded; every address value is legal and there is no wrap beyond the array.

Reset
REQ-028 While rst=1: state SHALL be CLEAR, clr_cnt=0, out_data=0, rd_valid=0, err_busy=0, busy=1; the array SHALL NOT be written.
REQ-029 rst asserted mid-clear or mid-operation SHALL restart clearing from address 0 after rst falls; a read or write presented in the same cycle as rst SHALL be discarded.
REQ-030 Array contents before the first clearing completes are undefined; after clearing completes, every word SHALL read 0.

Verification
REQ-031 RAM_ADDR_BITS=4, RAM_WIDTH=16: hold rst 3 cycles, then release -> busy=1 for exactly 16 cycles, then 0; reads of addresses 0..15 return 16'h0000.
REQ-032 Write addr 5, in_data 16'hBEEF, be=2'b11; next cycle read addr 5 -> one cycle later out_data=16'hBEEF and rd_valid=1 for one cycle.
REQ-033 After REQ-032, write addr 5, in_data 16'h1234, be=2'b01; then read addr 5 -> out_data=16'hBE34.
REQ-034 req=1 read of addr 3 issued 2 cycles after rst falls -> err_busy=1 for one cycle, rd_valid stays 0, out_data stays 0.
REQ-035 Assert rst while clr_cnt=9, release -> busy stays high 16 further cycles; a word written before reset reads 0 afterwards.
REQ-036 Reads of addr 1,2,3 on consecutive cycles after 16'h0011/16'h0022/16'h0033 were written -> out_data 0011, 0022, 0033 on three consecutive cycles, with rd_valid high throughout.

Source files
------------

// File: rtl/data_memory_bank.sv
// Single-port byte-lane data memory with a self-clearing sequencer.
// After reset, the array is zeroed one word per cycle before any access is accepted.
module data_memory_bank #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     write,
  input  logic [RAM_WIDTH/8-1:0]   be,
  input  logic [RAM_ADDR_BITS-1:0] addr_data,
  input  logic [RAM_WIDTH-1:0]     in_data,
  output logic [RAM_WIDTH-1:0]     out_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     err_busy
);

  localparam int LANES = RAM_WIDTH / 8;
  localparam int DEPTH = 1 << RAM_ADDR_BITS;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [RAM_ADDR_BITS-1:0] r_clr_cnt;
  logic [RAM_WIDTH-1:0]     r_ram [0:DEPTH-1];
  logic [RAM_WIDTH-1:0]     r_out_data;
  logic                     r_rd_valid;
  logic                     r_busy;
  logic                     r_err_busy;
  logic                     w_clr_we;
  logic                     w_wr_en;
  logic                     w_rd_en;
  logic                     w_err;

  // Next-state and access decode; requests during clearing are only flagged.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        w_err    = req;
        if (r_clr_cnt == {RAM_ADDR_BITS{1'b1}}) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_IDLE: begin
        w_wr_en     = req & write;
        w_rd_en     = req & ~write;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // State register and clear-address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= {RAM_ADDR_BITS{1'b0}};
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_we ? (r_clr_cnt + RAM_ADDR_BITS'(1)) : {RAM_ADDR_BITS{1'b0}};
      r_busy    <= (w_state_nxt == S_CLEAR);
    end
  end

  // Array write port: clearing has priority; user writes honour byte enables.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_ram[r_clr_cnt] <= {RAM_WIDTH{1'b0}};
      end else if (w_wr_en) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) begin
            r_ram[addr_data][8*i +: 8] <= in_data[8*i +: 8];
          end
        end
      end
    end
  end

  // Registered read data and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= {RAM_WIDTH{1'b0}};
      r_rd_valid <= 1'b0;
      r_err_busy <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      r_err_busy <= w_err;
      if (w_rd_en) begin
        r_out_data <= r_ram[addr_data];
      end
    end
  end

  assign out_data = r_out_data;
  assign rd_valid = r_rd_valid;
  assign busy     = r_busy;
  assign err_busy = r_err_busy;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank at 16 words x 16 bits.
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
module tb_data_memory_bank;

  localparam int W  = 16;
  localparam int AB = 4;

  logic          clk;
  logic          rst;
  logic          req;
  logic          write;
  logic [1:0]    be;
  logic [AB-1:0] addr_data;
  logic [W-1:0]  in_data;
  logic [W-1:0]  out_data;
  logic          rd_valid;
  logic          busy;
  logic          err_busy;

  int n_cmp = 0;
  int n_err = 0;

  data_memory_bank #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .write     (write),
    .be        (be),
    .addr_data (addr_data),
    .in_data   (in_data),
    .out_data  (out_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .err_busy  (err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    req = 1'b0; write = 1'b0; be = 2'b00; addr_data = 4'd0; in_data = 16'h0000;
  endtask

  task automatic do_wr(input logic [AB-1:0] a, input logic [W-1:0] d, input logic [1:0] b);
    req = 1'b1; write = 1'b1; be = b; addr_data = a; in_data = d;
  endtask

  task automatic do_rd(input logic [AB-1:0] a);
    req = 1'b1; write = 1'b0; be = 2'b00; addr_data = a; in_data = 16'h0000;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    // Reset held 3 cycles, with a read presented that must be discarded.
    step();
    do_rd(4'd3);
    step();
    step();
    chk("rst_busy", busy, 1'b1);
    chk("rst_out", out_data, 16'h0000);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_err", err_busy, 1'b0);
    rst = 1'b0;
    idle_in();

    // Clearing lasts exactly 16 cycles; a read 2 cycles in is rejected.
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("clr_busy", busy, (k < 16) ? 32'd1 : 32'd0);
      chk("clr_err", err_busy, (k == 2) ? 32'd1 : 32'd0);
      chk("clr_rdv", rd_valid, 1'b0);
      chk("clr_out", out_data, 16'h0000);
      if (k == 1) do_rd(4'd3);
      else        idle_in();
    end

    // Back-to-back reads of every address return zero.
    for (int a = 0; a < 16; a++) begin
      do_rd(a[AB-1:0]);
      step();
      chk("zero_out", out_data, 16'h0000);
      chk("zero_rdv", rd_valid, 1'b1);
    end
    idle_in();
    step();
    chk("idle_rdv", rd_valid, 1'b0);
    chk("idle_err", err_busy, 1'b0);

    // Full write then immediate read.
    do_wr(4'd5, 16'hBEEF, 2'b11);
    step();
    chk("wr_rdv", rd_valid, 1'b0);
    chk("wr_out_hold", out_data, 16'h0000);
    do_rd(4'd5);
    step();
    chk("rd5_out", out_data, 16'hBEEF);
    chk("rd5_rdv", rd_valid, 1'b1);
    idle_in();
    step();
    chk("rd5_pulse", rd_valid, 1'b0);
    chk("rd5_hold", out_data, 16'hBEEF);

    // Byte-lane writes: low lane, empty mask, high lane.
    do_wr(4'd5, 16'h1234, 2'b01);
    step();
    do_rd(4'd5);
    step();
    chk("be01_out", out_data, 16'hBE34);
    do_wr(4'd5, 16'hFFFF, 2'b00);
    step();
    chk("be00_err", err_busy, 1'b0);
    chk("be00_hold", out_data, 16'hBE34);
    do_rd(4'd5);
    step();
    chk("be00_out", out_data, 16'hBE34);
    do_wr(4'd5, 16'hABCD, 2'b10);
    step();
    do_rd(4'd5);
    step();
    chk("be10_out", out_data, 16'hAB34);

    // Top address.
    do_wr(4'd15, 16'hF00F, 2'b11);
    step();
    do_rd(4'd15);
    step();
    chk("top_out", out_data, 16'hF00F);

    // Three writes then three consecutive reads.
    do_wr(4'd1, 16'h0011, 2'b11);
    step();
    do_wr(4'd2, 16'h0022, 2'b11);
    step();
    do_wr(4'd3, 16'h0033, 2'b11);
    step();
    do_rd(4'd1);
    step();
    chk("seq1_out", out_data, 16'h0011);
    chk("seq1_rdv", rd_valid, 1'b1);
    do_rd(4'd2);
    step();
    chk("seq2_out", out_data, 16'h0022);
    chk("seq2_rdv", rd_valid, 1'b1);
    do_rd(4'd3);
    step();
    chk("seq3_out", out_data, 16'h0033);
    chk("seq3_rdv", rd_valid, 1'b1);
    idle_in();
    step();
    chk("seq_end_rdv", rd_valid, 1'b0);

    // Reset mid-operation, then again mid-clear at clr_cnt = 9.
    rst = 1'b1;
    do_wr(4'd9, 16'h1111, 2'b11);
    step();
    chk("rst2_busy", busy, 1'b1);
    chk("rst2_out", out_data, 16'h0000);
    rst = 1'b0;
    idle_in();
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("part_busy", busy, 1'b1);
    end
    rst = 1'b1;
    step();
    chk("rst3_busy", busy, 1'b1);
    chk("rst3_err", err_busy, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("reclr_busy", busy, (k < 16) ? 32'd1 : 32'd0);
    end

    // Previously written words read back as zero.
    do_rd(4'd5);
    step();
    chk("post5_out", out_data, 16'h0000);
    chk("post5_rdv", rd_valid, 1'b1);
    do_rd(4'd15);
    step();
    chk("post15_out", out_data, 16'h0000);
    do_rd(4'd2);
    step();
    chk("post2_out", out_data, 16'h0000);
    idle_in();
    step();
    chk("post_rdv", rd_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
